// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_arbiter
// Purpose  : Shares one single-ported memory between the instruction-fetch
//            port and the data-access port. One transaction in flight;
//            data has priority, with a starvation guard for fetch.
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch port
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ready,
  output logic [DATA_W-1:0] o_if_rdata,
  // data-access port
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ready,
  output logic [DATA_W-1:0] o_d_rdata,
  // backing memory
  output logic              o_mem_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_resp,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  // Counter must be able to hold STARVE_LIMIT itself (saturating value).
  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic              r_owner_d;    // 1 = data port owns the transaction
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_grant_d;
  logic w_any_req;

  // Data wins contention unless fetch has been passed over STARVE_LIMIT times.
  always_comb begin
    w_any_req = i_if_req | i_d_req;
    w_grant_d = i_d_req & (~i_if_req | (r_starve_cnt != c_starve_max));
  end

  // Transaction FSM: latch winner's command, issue, wait for response, retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner_d    <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_starve_cnt <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_ISSUE;
            r_owner_d <= w_grant_d;
            if (w_grant_d) begin
              r_we    <= i_d_we;
              r_addr  <= i_d_addr;
              r_wdata <= i_d_wdata;
              // Only a data grant that overtakes a waiting fetch counts.
              if (i_if_req) begin
                if (r_starve_cnt != c_starve_max) begin
                  r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
              end else begin
                r_starve_cnt <= '0;
              end
            end else begin
              r_we         <= 1'b0;
              r_addr       <= i_if_addr;
              r_wdata      <= '0;
              r_starve_cnt <= '0;
            end
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_mem_resp) begin
            r_state <= S_DONE;
            // Fetches always carry we = 0, so !r_we covers both read cases.
            if (!r_we) begin
              if (r_owner_d) r_d_rdata  <= i_mem_rdata;
              else           r_if_rdata <= i_mem_rdata;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes and ready pulses decode directly from the registered state.
  always_comb begin
    o_mem_valid = (r_state == S_ISSUE);
    o_if_ready  = (r_state == S_DONE) & ~r_owner_d;
    o_d_ready   = (r_state == S_DONE) &  r_owner_d;
    o_busy      = (r_state != S_IDLE);
    o_mem_we    = r_we;
    o_mem_addr  = r_addr;
    o_mem_wdata = r_wdata;
    o_if_rdata  = r_if_rdata;
    o_d_rdata   = r_d_rdata;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported backing memory between the pipeline's instruction-fetch port (IF) and data-access port (MEM stage).
- One transaction is outstanding at a time. Arbitration is data-priority, with a starvation guard for fetch.
- The core stalls each stage on its `*_ready`; the memory side uses a valid/response handshake with variable latency.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 2, consecutive data grants allowed while fetch is pending before fetch is forced to win (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid
- if_rdata  out  DATA_W  fetched word (registered, held)
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  load data (registered, held)
- mem_valid  out  1  one-cycle command strobe to memory
- mem_we  out  1  command is a write
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data
- mem_resp  in  1  memory completion (read data valid / write done)
- mem_rdata  in  DATA_W  memory read data, valid with mem_resp
- busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high on clk.
  - State goes to IDLE; starve_cnt = 0.
  - All outputs are 0: if_ready, d_ready, mem_valid, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, busy.
- FSM states: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE:
  - Requests are sampled only here.
  - If any request is pending, latch owner (IF/D), address, we, and wdata; go to ISSUE.
  - Fetch commands always have we = 0 and wdata = 0.
- Arbitration in IDLE:
  - Only one request pending: that requester wins.
  - Both pending: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - starve_cnt increments on a data grant made while if_req = 1.
  - starve_cnt clears on any fetch grant, or on a data grant with if_req = 0.
  - starve_cnt saturates at STARVE_LIMIT.
- ISSUE:
  - mem_valid = 1 for exactly one cycle; mem_we/mem_addr/mem_wdata come from the latched fields.
  - Always go to WAIT.
  - mem_we/mem_addr/mem_wdata hold their latched values in all other states; mem_valid = 0 outside ISSUE.
- WAIT:
  - Stay until mem_resp = 1.
  - On mem_resp with a read: capture mem_rdata into if_rdata (owner IF) or d_rdata (owner D, d_we = 0).
  - A data write leaves d_rdata unchanged.
  - Then go to DONE.
- DONE:
  - Pulse the owner's ready for exactly one cycle; the other port's ready stays 0. Go to IDLE.
  - A requester keeping its req high into the following IDLE cycle is treated as a new request.
- mem_resp is ignored in IDLE, ISSUE and DONE. No response may be generated from it.
- Latency: grant cycle N (IDLE), mem_valid at N+1, first possible mem_resp at N+2, ready at N+3.
  - Minimum 4 cycles per transaction with 1-cycle memory latency.
  - Each extra memory wait cycle adds one cycle.
- Requests deasserted before being sampled in IDLE are never issued. Deasserting after grant is illegal: the transaction still completes and the ready pulse is still generated.
- Reset mid-transaction (ISSUE/WAIT/DONE):
  - Abort to IDLE with no ready pulse.
  - A late mem_resp afterwards is ignored.
- if_ready and d_ready are never high in the same cycle.
- if_rdata and d_rdata change only on a captured read or on reset.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x10; memory answers 1 cycle after mem_valid with 0x00500093 -> mem_valid at cycle 1 with mem_addr = 0x10, mem_we = 0; if_ready pulses at cycle 3; if_rdata = 0x00500093.
- Store then load: d_req with d_we = 1, d_addr = 0x40, d_wdata = 0xDEADBEEF -> mem_we = 1, mem_wdata = 0xDEADBEEF, d_ready pulse, d_rdata unchanged. Then a load from 0x40 returning 0xDEADBEEF -> d_rdata = 0xDEADBEEF.
- Contention and starvation (STARVE_LIMIT = 2): if_req and d_req held high continuously, with each d_ready followed by a new d_req -> grant order D, D, IF, D, D, IF.
- Variable latency: mem_resp delayed 5 cycles after mem_valid -> busy stays high throughout, exactly one ready pulse 1 cycle after mem_resp, and no second mem_valid in between.
- Reset in WAIT, then mem_resp = 1 next cycle -> no ready pulse, busy = 0, all outputs 0. A subsequent fetch completes normally.
- Spurious mem_resp in IDLE with mem_rdata = 0x12345678 -> if_rdata and d_rdata unchanged, no ready pulse.
